cook_sequencer: RTL and testbench
=================================

# cook_sequencer

Multi-stage cooking program controller for the microwave datapath. Holds up to STAGES programmed stages (time in BCD, power level), loads each stage's time into the countdown timer digit by digit, enables the countdown, and duty-cycles the magnetron per stage power. It advances to the next stage on timer zero. It sits between the keypad/encoder front end and the timer/magnetron, replacing the single-shot start/stop control path for programmed cooking.

## Interface
- STAGES, 4: number of program slots; power of two, 2..8.
- PWM_PERIOD, 10: magnetron duty window in clock cycles; power level p gives p on-cycles per window.
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- prog_we  in  1  write stage slot prog_addr; ignored while busy.
- prog_addr  in  log2(STAGES)  slot index.
- prog_mins, prog_tens, prog_ones  in  4 each  BCD stage time.
- prog_power  in  4  power level 0..10; values above 10 are stored as 10.
- prog_len  in  log2(STAGES)+1  stages to run; sampled on start.
- start  in  1  run request, or resume from PAUSE.
- abort  in  1  cancel program.
- door_closed  in  1  door interlock.
- timer_zero  in  1  timer at 0:00.
- timer_number  out  4  BCD digit being loaded.
- timer_loadn  out  1  active-low digit load strobe; one digit is shifted in per low cycle.
- timer_clearn  out  1  active-low timer clear pulse.
- timer_enable  out  1  countdown enable.
- mag_on  out  1  magnetron drive.
- busy  out  1  high in every state except IDLE.
- paused  out  1  high in PAUSE.
- stage  out  log2(STAGES)  current stage index.
- done  out  1  one-cycle pulse at program completion.

## Operation
- Slot storage is STAGES entries × {mins, tens, ones, power}, all zero at reset.
- On load, digits are clamped: any digit above 9 loads as 9; tens above 5 loads as 5.
- States: IDLE, CLEAR, LOAD_M, LOAD_T, LOAD_O, RUN, PAUSE, NEXT, DONE.
- IDLE:
  - start && door_closed && prog_len≠0 → CLEAR. Latch len = min(prog_len, STAGES) and set stage=0.
  - start under any other condition is ignored.
- CLEAR: timer_clearn=0 for one cycle → LOAD_M.
- LOAD_M, LOAD_T, LOAD_O: timer_loadn=0 for one cycle each, with timer_number = mins, tens, ones of the current slot.
- After LOAD_O:
  - If all three stage digits are zero → NEXT (stage skipped; magnetron never driven).
  - Otherwise → RUN, with the PWM counter cleared to 0.
- RUN:
  - timer_enable=1.
  - The PWM counter wraps from PWM_PERIOD-1 to 0.
  - mag_on = door_closed && (pwm_cnt < power). The door_closed gating is combinational. Power 0 keeps mag_on off but the timer still runs; power ≥ PWM_PERIOD keeps mag_on solid.
- RUN exits, in priority order:
  1. abort → IDLE.
  2. !door_closed → PAUSE.
  3. timer_zero → NEXT.
- PAUSE:
  - timer_enable=0, mag_on=0, PWM counter held.
  - abort → IDLE.
  - start && door_closed → RUN.
- NEXT:
  - stage == len-1 → DONE.
  - Otherwise stage+1 → CLEAR.
- DONE: done=1 for one cycle → IDLE; stage returns to 0.
- abort in any non-IDLE state → IDLE, and timer_clearn is driven low for the transition cycle.
- Priority across all states: abort > door > timer_zero > start.
- prog_we is accepted only in IDLE. A write and a start in the same cycle: the write lands first, and the program uses the new value.

## Timing
- Reset values: timer_number=0, timer_loadn=1, timer_clearn=1, timer_enable=0, mag_on=0, busy=0, paused=0, stage=0, done=0; state=IDLE.
- Asserting resetn mid-program forces the reset values immediately. The timer is not explicitly cleared; the timer's own clear is expected on the system reset.
- All outputs except mag_on are registered Moore outputs of state.
- Start to run: start sampled at edge k gives CLEAR in cycle k+1, LOAD_M in k+2, LOAD_T in k+3, LOAD_O in k+4, and RUN with timer_enable=1 in k+5. mag_on is high in cycle k+5 if power>0.
- timer_zero must reflect the loaded value by the first RUN cycle.
- Stage switch: timer_zero sampled in RUN at edge j gives NEXT in j+1, CLEAR in j+2, and next RUN in j+6.
- Final stage: done pulses in cycle j+2; busy falls in j+3.
- Door open: mag_on falls in the same cycle (combinational). timer_enable falls one cycle later.

## Test plan
- One stage {0,3,0} at power 10: start → load pulses carry numbers 0,3,0 on cycles k+2..k+4. mag_on stays solid through RUN; force timer_zero → done pulse, then IDLE.
- Power 3 with PWM_PERIOD 10 → mag_on pattern is 3 high, 7 low, repeating, aligned to RUN entry.
- Two stages, with slot 0 set to all zeros → slot 0 is skipped with no mag_on; stage=1 loads and RUN begins 5 cycles after the first NEXT.
- Drop door_closed mid-RUN → mag_on low the same cycle, paused=1. start with the door open is ignored. Close the door, then start → RUN resumes with the PWM phase preserved.
- abort during LOAD_T → IDLE next cycle, timer_clearn low on the transition, busy=0.
- prog_ones=12 and prog_tens=7 → loaded as 9 and 5. prog_we while busy leaves the slot unchanged. Assert resetn mid-RUN → all outputs return to their reset values.

Source files
------------

// File: rtl/cook_sequencer.sv
// Multi-stage cooking program controller: stores programmed stages, loads each
// stage time into the countdown timer digit by digit, and duty-cycles the magnetron.
`timescale 1ns/1ps
module cook_sequencer #(
  parameter int STAGES     = 4,
  parameter int PWM_PERIOD = 10
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      prog_we,
  input  logic [$clog2(STAGES)-1:0] prog_addr,
  input  logic [3:0]                prog_mins,
  input  logic [3:0]                prog_tens,
  input  logic [3:0]                prog_ones,
  input  logic [3:0]                prog_power,
  input  logic [$clog2(STAGES):0]   prog_len,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      door_closed,
  input  logic                      timer_zero,
  output logic [3:0]                timer_number,
  output logic                      timer_loadn,
  output logic                      timer_clearn,
  output logic                      timer_enable,
  output logic                      mag_on,
  output logic                      busy,
  output logic                      paused,
  output logic [$clog2(STAGES)-1:0] stage,
  output logic                      done
);

  localparam int AW = $clog2(STAGES);
  localparam int LW = AW + 1;
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [LW-1:0] STAGES_L = LW'(STAGES);
  localparam logic [PW-1:0] PWM_LAST = PW'(PWM_PERIOD - 1);

  typedef enum logic [3:0] {
    IDLE, CLEAR, LOAD_M, LOAD_T, LOAD_O, RUN, PAUSE, NEXT, DONE
  } state_t;

  state_t state, state_next;
  logic [3:0]    slot_mins  [STAGES];
  logic [3:0]    slot_tens  [STAGES];
  logic [3:0]    slot_ones  [STAGES];
  logic [3:0]    slot_power [STAGES];
  logic [LW-1:0] len;
  logic [PW-1:0] pwm_cnt;
  logic [3:0]    number_next;
  logic          abort_exit;
  logic          cur_zero;
  logic          last_stage;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [3:0] clamp_power(input logic [3:0] p);
    return (p > 4'd10) ? 4'd10 : p;
  endfunction

  assign cur_zero   = (slot_mins[stage] | slot_tens[stage] | slot_ones[stage]) == 4'd0;
  assign last_stage = {1'b0, stage} == (len - LW'(1));
  // Door gating is combinational so the magnetron drops in the same cycle the door opens
  assign mag_on     = door_closed && (state == RUN) && (32'(pwm_cnt) < 32'(slot_power[stage]));

  always_comb begin
    state_next = state;
    abort_exit = 1'b0;
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
      abort_exit = 1'b1;
    end else begin
      case (state)
        IDLE:    if (start && door_closed && (prog_len != '0)) state_next = CLEAR;
        CLEAR:   state_next = LOAD_M;
        LOAD_M:  state_next = LOAD_T;
        LOAD_T:  state_next = LOAD_O;
        LOAD_O:  state_next = cur_zero ? NEXT : RUN;
        RUN: begin
          if (!door_closed)    state_next = PAUSE;
          else if (timer_zero) state_next = NEXT;
        end
        PAUSE:   if (start && door_closed) state_next = RUN;
        NEXT:    state_next = last_stage ? DONE : CLEAR;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    number_next = 4'd0;
    case (state_next)
      LOAD_M:  number_next = clamp_digit(slot_mins[stage], 4'd9);
      LOAD_T:  number_next = clamp_digit(slot_tens[stage], 4'd5);
      LOAD_O:  number_next = clamp_digit(slot_ones[stage], 4'd9);
      default: number_next = 4'd0;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      timer_number <= 4'd0;
      timer_loadn  <= 1'b1;
      timer_clearn <= 1'b1;
      timer_enable <= 1'b0;
      busy         <= 1'b0;
      paused       <= 1'b0;
      done         <= 1'b0;
      stage        <= '0;
      len          <= '0;
      pwm_cnt      <= '0;
    end else begin
      state        <= state_next;
      timer_number <= number_next;
      timer_loadn  <= !(state_next inside {LOAD_M, LOAD_T, LOAD_O});
      timer_clearn <= !((state_next == CLEAR) || abort_exit);
      timer_enable <= (state_next == RUN);
      busy         <= (state_next != IDLE);
      paused       <= (state_next == PAUSE);
      done         <= (state_next == DONE);
      if (state_next == IDLE) begin
        stage <= '0;
      end else if ((state == IDLE) && (state_next == CLEAR)) begin
        stage <= '0;
        len   <= (prog_len > STAGES_L) ? STAGES_L : prog_len;
      end else if ((state == NEXT) && (state_next == CLEAR)) begin
        stage <= stage + AW'(1);
      end
      // PWM phase counts RUN cycles; PAUSE holds it so resuming keeps the duty phase
      if (state == LOAD_O) begin
        pwm_cnt <= '0;
      end else if (state == RUN) begin
        pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) begin
        slot_mins[i]  <= 4'd0;
        slot_tens[i]  <= 4'd0;
        slot_ones[i]  <= 4'd0;
        slot_power[i] <= 4'd0;
      end
    end else if (prog_we && (state == IDLE)) begin
      slot_mins[prog_addr]  <= prog_mins;
      slot_tens[prog_addr]  <= prog_tens;
      slot_ones[prog_addr]  <= prog_ones;
      slot_power[prog_addr] <= clamp_power(prog_power);
    end
  end

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: per-cycle expected traces built from stage programs
// (directed tables plus randomized programs) compared against the DUT outputs.
`timescale 1ns/1ps
module tb_cook_sequencer;
  localparam int STAGES     = 4;
  localparam int PWM_PERIOD = 10;

  logic       clock = 1'b0;
  logic       resetn;
  logic       prog_we;
  logic [1:0] prog_addr;
  logic [3:0] prog_mins, prog_tens, prog_ones, prog_power;
  logic [2:0] prog_len;
  logic       start, abort, door_closed, timer_zero;
  logic [3:0] timer_number;
  logic       timer_loadn, timer_clearn, timer_enable, mag_on, busy, paused, done;
  logic [1:0] stage;

  always #5 clock = ~clock;

  cook_sequencer #(.STAGES(STAGES), .PWM_PERIOD(PWM_PERIOD)) dut (
    .clock(clock), .resetn(resetn), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_mins(prog_mins), .prog_tens(prog_tens), .prog_ones(prog_ones),
    .prog_power(prog_power), .prog_len(prog_len), .start(start), .abort(abort),
    .door_closed(door_closed), .timer_zero(timer_zero), .timer_number(timer_number),
    .timer_loadn(timer_loadn), .timer_clearn(timer_clearn), .timer_enable(timer_enable),
    .mag_on(mag_on), .busy(busy), .paused(paused), .stage(stage), .done(done)
  );

  // Observed outputs: {clearn, loadn, number, enable, mag, busy, paused, done, stage}
  logic [12:0] act;
  assign act = {timer_clearn, timer_loadn, timer_number, timer_enable, mag_on,
                busy, paused, done, stage};

  typedef struct {
    bit          st;
    bit          door;
    bit          tz;
    bit          ab;
    bit          we;
    logic [12:0] exp;
  } vec_t;

  vec_t  q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string tag;

  // Reference copy of the slot contents as the bench wrote them
  int sm[STAGES], stt[STAGES], so[STAGES], sp[STAGES];
  int run_len[STAGES], pause_at[STAGES], pause_len[STAGES];

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [12:0] ex(input bit clr, input bit ld, input int num, input bit en,
                                     input bit mag, input bit bsy, input bit pz, input bit dn,
                                     input int stg);
    return {clr, ld, 4'(num), en, mag, bsy, pz, dn, 2'(stg)};
  endfunction

  function automatic logic [12:0] idle_x();
    return ex(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void push(input bit st, input bit door, input bit tz, input bit ab,
                               input bit we, input logic [12:0] e);
    vec_t v;
    v.st = st; v.door = door; v.tz = tz; v.ab = ab; v.we = we; v.exp = e;
    q.push_back(v);
  endfunction

  function automatic void model_write(input int a, input int m, input int t, input int o,
                                      input int p);
    sm[a] = m; stt[a] = t; so[a] = o; sp[a] = mn(p, 10);
  endfunction

  task automatic check(input string nm, input logic [12:0] got, input logic [12:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  task automatic apply(input int n);
    int lim;
    lim = (n < 0 || n > q.size()) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      start = q[i].st; door_closed = q[i].door; timer_zero = q[i].tz;
      abort = q[i].ab; prog_we = q[i].we;
      #1 check($sformatf("%s[%0d]", tag, i), act, q[i].exp);
    end
    q.delete();
  endtask

  task automatic prog_slot(input int a, input int m, input int t, input int o, input int p);
    @(negedge clock);
    start = 0; abort = 0; timer_zero = 0; door_closed = 1;
    prog_we = 1; prog_addr = 2'(a);
    prog_mins = 4'(m); prog_tens = 4'(t); prog_ones = 4'(o); prog_power = 4'(p);
    model_write(a, m, t, o, p);
    @(negedge clock);
    prog_we = 0;
  endtask

  // Expected cycle trace of a whole program run, derived from the stage list
  function automatic void gen_program(input int len, input bit start_we, input bit busy_we);
    int L, ph, r;
    L = mn(len, STAGES);
    if (start_we) model_write(prog_addr, prog_mins, prog_tens, prog_ones, prog_power);
    push(1, 1, 0, 0, start_we, idle_x());
    for (int s = 0; s < L; s++) begin
      push(0, 1, 0, 0, busy_we, ex(0, 1, 0, 0, 0, 1, 0, 0, s));
      push(0, 1, 0, 0, busy_we, ex(1, 0, mn(sm[s], 9), 0, 0, 1, 0, 0, s));
      push(0, 1, 0, 0, busy_we, ex(1, 0, mn(stt[s], 5), 0, 0, 1, 0, 0, s));
      push(0, 1, 0, 0, busy_we, ex(1, 0, mn(so[s], 9), 0, 0, 1, 0, 0, s));
      if (sm[s] + stt[s] + so[s] != 0) begin
        ph = 0;
        r  = run_len[s];
        for (int i = 0; i < r; i++) begin
          if (i == pause_at[s] && pause_len[s] > 0) begin
            push(0, 0, 0, 0, busy_we, ex(1, 1, 0, 1, 0, 1, 0, 0, s));
            ph++;
            for (int k = 0; k < pause_len[s]; k++) begin
              if (k == pause_len[s] - 1)
                push(1, 1, 0, 0, busy_we, ex(1, 1, 0, 0, 0, 1, 1, 0, s));
              else
                push(k == 0, 0, 0, 0, busy_we, ex(1, 1, 0, 0, 0, 1, 1, 0, s));
            end
          end else begin
            push(0, 1, i == r - 1, 0, busy_we,
                 ex(1, 1, 0, 1, (ph % PWM_PERIOD) < sp[s], 1, 0, 0, s));
            ph++;
          end
        end
      end
      push(0, 1, 0, 0, busy_we, ex(1, 1, 0, 0, 0, 1, 0, 0, s));
    end
    push(0, 1, 0, 0, busy_we, ex(1, 1, 0, 0, 0, 1, 0, 1, L - 1));
    push(0, 1, 0, 0, 0, idle_x());
  endfunction

  function automatic void clear_pauses();
    for (int s = 0; s < STAGES; s++) begin
      pause_len[s] = 0; pause_at[s] = 0; run_len[s] = 3;
    end
  endfunction

  initial begin
    resetn = 1; prog_we = 0; prog_addr = 0; prog_mins = 0; prog_tens = 0; prog_ones = 0;
    prog_power = 0; prog_len = 1; start = 0; abort = 0; door_closed = 1; timer_zero = 0;
    for (int s = 0; s < STAGES; s++) model_write(s, 0, 0, 0, 0);
    clear_pauses();
    #1 resetn = 0;
    #1 check("reset", act, idle_x());
    @(negedge clock);
    resetn = 1;

    // Single stage 0:30 at full power
    tag = "stage030";
    prog_slot(0, 0, 3, 0, 10);
    prog_len = 1;
    push(1, 1, 0, 0, 0, idle_x());
    push(0, 1, 0, 0, 0, ex(0, 1, 0, 0, 0, 1, 0, 0, 0));
    push(0, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 0, 0, 0));
    push(0, 1, 0, 0, 0, ex(1, 0, 3, 0, 0, 1, 0, 0, 0));
    push(0, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) push(0, 1, 0, 0, 0, ex(1, 1, 0, 1, 1, 1, 0, 0, 0));
    push(0, 1, 1, 0, 0, ex(1, 1, 0, 1, 1, 1, 0, 0, 0));
    push(0, 1, 0, 0, 0, ex(1, 1, 0, 0, 0, 1, 0, 0, 0));
    push(0, 1, 0, 0, 0, ex(1, 1, 0, 0, 0, 1, 0, 1, 0));
    push(0, 1, 0, 0, 0, idle_x());
    apply(-1);

    tag = "power3";
    prog_slot(0, 1, 0, 0, 3);
    clear_pauses(); run_len[0] = 23;
    gen_program(1, 0, 0);
    apply(-1);

    tag = "skip0";
    prog_slot(0, 0, 0, 0, 7);
    prog_slot(1, 0, 0, 5, 5);
    prog_len = 2;
    clear_pauses(); run_len[1] = 4;
    gen_program(2, 0, 0);
    apply(-1);

    tag = "door";
    prog_slot(0, 0, 1, 0, 4);
    prog_len = 1;
    clear_pauses(); run_len[0] = 15; pause_at[0] = 2; pause_len[0] = 3;
    gen_program(1, 0, 0);
    apply(-1);

    tag = "abort";
    prog_slot(0, 2, 3, 4, 5);
    push(1, 1, 0, 0, 0, idle_x());
    push(0, 1, 0, 0, 0, ex(0, 1, 0, 0, 0, 1, 0, 0, 0));
    push(0, 1, 0, 0, 0, ex(1, 0, 2, 0, 0, 1, 0, 0, 0));
    push(0, 1, 0, 1, 0, ex(1, 0, 3, 0, 0, 1, 0, 0, 0));
    push(0, 1, 0, 0, 0, ex(0, 1, 0, 0, 0, 0, 0, 0, 0));
    push(0, 1, 0, 0, 0, idle_x());
    apply(-1);

    tag = "len0";
    prog_len = 0;
    push(1, 1, 0, 0, 0, idle_x());
    push(0, 1, 0, 0, 0, idle_x());
    apply(-1);
    tag = "dooropen_start";
    prog_len = 1;
    push(1, 0, 0, 0, 0, idle_x());
    push(0, 1, 0, 0, 0, idle_x());
    apply(-1);

    tag = "clamp_we_busy";
    prog_slot(0, 1, 7, 12, 4);
    prog_mins = 9; prog_tens = 9; prog_ones = 9; prog_power = 1; prog_addr = 0;
    clear_pauses(); run_len[0] = 3;
    gen_program(1, 0, 1);
    apply(-1);
    tag = "after_busy_we";
    gen_program(1, 0, 0);
    apply(-1);
    tag = "we_with_start";
    prog_mins = 0; prog_tens = 2; prog_ones = 1; prog_power = 15; prog_addr = 0;
    gen_program(1, 1, 0);
    apply(-1);

    tag = "reset_mid_run";
    prog_slot(0, 2, 0, 0, 5);
    clear_pauses(); run_len[0] = 10;
    gen_program(1, 0, 0);
    apply(8);
    @(negedge clock);
    resetn = 0;
    #1 check("reset_mid_run_out", act, idle_x());
    for (int s = 0; s < STAGES; s++) model_write(s, 0, 0, 0, 0);
    @(negedge clock);
    resetn = 1;
    tag = "after_reset";
    gen_program(1, 0, 0);
    apply(-1);

    for (int it = 0; it < 15; it++) begin
      tag = $sformatf("rand%0d", it);
      for (int a = 0; a < STAGES; a++) begin
        if ($urandom_range(0, 3) == 0)
          prog_slot(a, 0, 0, 0, $urandom_range(0, 15));
        else
          prog_slot(a, $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15));
      end
      prog_len = 3'($urandom_range(1, 7));
      for (int s = 0; s < STAGES; s++) begin
        run_len[s] = $urandom_range(1, 25);
        if (run_len[s] >= 2 && $urandom_range(0, 1) == 1) begin
          pause_at[s]  = $urandom_range(0, run_len[s] - 2);
          pause_len[s] = $urandom_range(1, 4);
        end else begin
          pause_at[s]  = 0;
          pause_len[s] = 0;
        end
      end
      gen_program(int'(prog_len), 0, 0);
      apply(-1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
